// File: rtl/mult_div_sequencer_if.sv
// EX-stage handshake and result bus between the pipeline and the multiply/divide sequencer.
interface mult_div_sequencer_if #(
   parameter int BITS_DATA  = 32,
   parameter int BITS_FUNCT = 6
);
   logic                  i_start;
   logic [BITS_FUNCT-1:0] i_funct;
   logic [BITS_DATA-1:0]  i_rs_data;
   logic [BITS_DATA-1:0]  i_rt_data;
   logic                  i_flush;
   logic                  o_stall;
   logic                  o_busy;
   logic                  o_done;
   logic                  o_div_by_zero;
   logic [BITS_DATA-1:0]  o_hi;
   logic [BITS_DATA-1:0]  o_lo;

   // Pipeline side: issues operations and consumes HI/LO.
   modport master (
      output i_start, i_funct, i_rs_data, i_rt_data, i_flush,
      input  o_stall, o_busy, o_done, o_div_by_zero, o_hi, o_lo
   );

   // Sequencer side.
   modport slave (
      input  i_start, i_funct, i_rs_data, i_rt_data, i_flush,
      output o_stall, o_busy, o_done, o_div_by_zero, o_hi, o_lo
   );
endinterface

// File: rtl/mult_div_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one bit per cycle on operand magnitudes,
// sign fix-up in a single cycle, results held in HI/LO until the next completion.
module mult_div_sequencer #(
   parameter int BITS_DATA  = 32,
   parameter int BITS_FUNCT = 6,
   parameter int N_ITER     = BITS_DATA
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   mult_div_sequencer_if.slave  bus
);
   localparam int BITS_CNT = $clog2(N_ITER + 1);

   localparam logic [BITS_FUNCT-1:0] FUNCT_MULT  = BITS_FUNCT'(6'b011000);
   localparam logic [BITS_FUNCT-1:0] FUNCT_MULTU = BITS_FUNCT'(6'b011001);
   localparam logic [BITS_FUNCT-1:0] FUNCT_DIV   = BITS_FUNCT'(6'b011010);
   localparam logic [BITS_FUNCT-1:0] FUNCT_DIVU  = BITS_FUNCT'(6'b011011);

   typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

   state_t                   state;
   logic [BITS_CNT-1:0]      count;
   logic [BITS_DATA-1:0]     opnd;        // multiplicand or divisor magnitude
   logic [2*BITS_DATA-1:0]   acc;         // {partial/remainder, multiplier/quotient}
   logic                     is_div;
   logic                     neg_result;  // operand signs differ (signed ops only)
   logic                     neg_rem;     // dividend was negative (signed ops only)
   logic                     busy;
   logic                     done;
   logic                     div_by_zero;
   logic [BITS_DATA-1:0]     hi;
   logic [BITS_DATA-1:0]     lo;

   logic                     valid_funct;
   logic                     accept;
   logic                     is_signed_op;
   logic                     is_div_op;
   logic                     rs_neg;
   logic                     rt_neg;
   logic [BITS_DATA-1:0]     rs_mag;
   logic [BITS_DATA-1:0]     rt_mag;
   logic [BITS_DATA:0]       mul_sum;
   logic [BITS_DATA:0]       div_shift;
   logic [BITS_DATA:0]       div_trial;
   logic [2*BITS_DATA-1:0]   mul_next;
   logic [2*BITS_DATA-1:0]   div_next;
   logic [2*BITS_DATA-1:0]   prod_fix;
   logic [BITS_DATA-1:0]     quot_fix;
   logic [BITS_DATA-1:0]     rem_fix;

   // Decode the request, form operand magnitudes and one shift-add / shift-subtract step.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      valid_funct  = bus.i_funct inside {FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
      accept       = i_reset && (state == IDLE) && bus.i_start && valid_funct && !bus.i_flush;
      is_signed_op = ~bus.i_funct[0];
      is_div_op    = bus.i_funct[1];
      rs_neg       = is_signed_op & bus.i_rs_data[BITS_DATA-1];
      rt_neg       = is_signed_op & bus.i_rt_data[BITS_DATA-1];
      rs_mag       = rs_neg ? -bus.i_rs_data : bus.i_rs_data;
      rt_mag       = rt_neg ? -bus.i_rt_data : bus.i_rt_data;

      // Multiply: add multiplicand when the multiplier LSB is set, then shift right.
      mul_sum  = {1'b0, acc[2*BITS_DATA-1:BITS_DATA]} + {1'b0, (acc[0] ? opnd : '0)};
      mul_next = {mul_sum, acc[BITS_DATA-1:1]};

      // Divide: shift the next dividend bit into the remainder and try the subtraction;
      // a borrow means restore (keep the shifted remainder) and emit a 0 quotient bit.
      div_shift = {acc[2*BITS_DATA-1:BITS_DATA], acc[BITS_DATA-1]};
      div_trial = div_shift - {1'b0, opnd};
      div_next  = div_trial[BITS_DATA]
                ? {div_shift[BITS_DATA-1:0], acc[BITS_DATA-2:0], 1'b0}
                : {div_trial[BITS_DATA-1:0], acc[BITS_DATA-2:0], 1'b1};

      prod_fix = neg_result ? -acc : acc;
      quot_fix = neg_result ? -acc[BITS_DATA-1:0] : acc[BITS_DATA-1:0];
      rem_fix  = neg_rem ? -acc[2*BITS_DATA-1:BITS_DATA] : acc[2*BITS_DATA-1:BITS_DATA];
   end

   // Sequencer FSM with registered status outputs and the HI/LO result registers.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
         state       <= IDLE;
         count       <= '0;
         opnd        <= '0;
         acc         <= '0;
         is_div      <= 1'b0;
         neg_result  <= 1'b0;
         neg_rem     <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
      end else begin
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  is_div     <= is_div_op;
                  neg_result <= rs_neg ^ rt_neg;
                  neg_rem    <= rs_neg;
                  count      <= BITS_CNT'(N_ITER);
                  if (is_div_op) begin
                     opnd <= rt_mag;
                     acc  <= {{BITS_DATA{1'b0}}, rs_mag};
                  end else begin
                     opnd <= rs_mag;
                     acc  <= {{BITS_DATA{1'b0}}, rt_mag};
                  end
                  if (is_div_op && (bus.i_rt_data == '0)) begin
                     state       <= DONE;
                     done        <= 1'b1;
                     div_by_zero <= 1'b1;
                  end else begin
                     state <= CALC;
                     busy  <= 1'b1;
                  end
               end
            end
            CALC: begin
               if (bus.i_flush) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  acc   <= is_div ? div_next : mul_next;
                  count <= count - BITS_CNT'(1);
                  if (count == BITS_CNT'(1)) state <= SIGN;
               end
            end
            SIGN: begin
               busy <= 1'b0;
               if (bus.i_flush) begin
                  state <= IDLE;
               end else begin
                  if (is_div) begin
                     hi <= rem_fix;
                     lo <= quot_fix;
                  end else begin
                     hi <= prod_fix[2*BITS_DATA-1:BITS_DATA];
                     lo <= prod_fix[BITS_DATA-1:0];
                  end
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.o_stall       = busy | accept;
   assign bus.o_busy        = busy;
   assign bus.o_done        = done;
   assign bus.o_div_by_zero = div_by_zero;
   assign bus.o_hi          = hi;
   assign bus.o_lo          = lo;
endmodule
